seven_segment_capture: RTL and testbench
========================================

# seven_segment_capture

- Receive-side counterpart of the seven-segment display driver.
- Samples a time-multiplexed, active-low seven-segment bus (segments plus per-digit anode enables) and decodes each stable pattern back to the driver's 5-bit digit code (bit 4 = blank, bits 3:0 = hex).
- Assembles one code per digit into a frame word and presents it on a valid/ready output.
- Sits on the display bus of the data-stream design so displayed values can be read back by the self-check logic and by benches.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; range 1..8.
- `STABLE_CYCLES`, default 8: consecutive identical samples required before a digit is accepted; minimum 1.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `seg`, input, 7: active-low segments; bit 0 = a, 1 = b, 2 = c, 3 = d, 4 = e, 5 = f, 6 = g.
- `an`, input, `DIGITS`: active-low digit enables; bit i low selects digit i.
- `out_data`, output, 5*`DIGITS`: frame word; digit i occupies bits 5i+4..5i.
- `out_err`, output, 2: bit 0 = an invalid pattern was captured in the frame; bit 1 = a multi-hot `an` was seen during the frame.
- `out_valid`, output, 1: frame available.
- `out_ready`, input, 1: consumer accepts the frame.

## Operation
- Decode table (`seg`, written g..a, to code):
  - 1111111 = 10000 (blank)
  - 1000000 = 0, 1111001 = 1, 0100100 = 2, 0110000 = 3
  - 0011001 = 4, 0010010 = 5, 0000010 = 6, 1111000 = 7
  - 0000000 = 8, 0010000 = 9, 0001000 = A, 0000011 = b
  - 1000110 = C, 0100001 = d, 0000110 = E, 0001110 = F
  - Any other pattern = 11111; sets the frame's `out_err[0]`.
- Input stage: `seg` and `an` are registered into `seg_q` and `an_q` every cycle.
- Stability counter:
  - Increments while {`seg_q`,`an_q`} equals its previous value; saturates at `STABLE_CYCLES`-1.
  - Clears to 0 on any change.
- Accept:
  - Occurs when the counter reaches `STABLE_CYCLES`-1, `an_q` has exactly one low bit, and the current stable episode has not yet been accepted.
  - An accept writes the decoded code into slot i and sets `mask[i]`.
  - Only one accept is allowed per stable episode; a new accept requires an input change first.
- `an_q` all ones: no accept; the counter still runs.
- `an_q` with more than one bit low: no accept; sets the frame's `out_err[1]`.
- Same digit accepted again in one frame: latest value overwrites the slot.
- State machine:
  - SCAN: performs accepts. When an accept makes `mask` all ones, go to HOLD on the next edge.
  - HOLD: `out_valid`=1; `out_data` and `out_err` are frozen. Accepts and error accumulation are suppressed; the stability counter keeps tracking the input. On `out_valid`&&`out_ready`, clear `mask` and errors and go to SCAN.
- Reset mid-operation:
  - `mask`, slots, errors and counter clear immediately.
  - State returns to SCAN, discarding any partial or held frame.
- Reset values:
  - `out_data`=0, `out_err`=0, `out_valid`=0.
  - Counter=0, `mask`=0.
  - `seg_q`=7'h7F, `an_q`=all ones.

## Timing
- Digit latency: a stable input at cycle 0 is accepted at the edge ending cycle `STABLE_CYCLES` (1 register stage + `STABLE_CYCLES` samples).
- `out_valid` rises on the edge after the final digit's accept.
- `out_valid` holds until the handshake; `out_data` and `out_err` are stable throughout.
- Handshake edge:
  - `out_valid` falls on that same edge.
  - The earliest new accept is on the following edge.
  - Throughput is bounded by the input scan; no back-to-back frames without a new accept.
- Inputs are treated as asynchronous to `clk` only when the configuration option below is compiled in.

## Configuration
- `SEVSEG_CAPTURE_SYNC_EN` defined:
  - `seg` and `an` pass through a two-flop synchronizer ahead of the input stage.
  - Adds 2 cycles to digit latency.
  - Synchronizer flops reset to all ones.
- Undefined: no synchronizer; inputs must be synchronous to `clk`.

## Test plan
- Test 1, code 3 on every digit:
  - Stimulus: `DIGITS`=4, `STABLE_CYCLES`=8; drive each digit for 12 cycles with 0110000.
  - Response: `out_data`=20'h18C63; `out_valid` rises exactly 1 cycle after digit 3's accept; `out_err`=0.
- Test 2, glitch rejection:
  - Stimulus: digit 0 = 1111001 held 5 cycles, then a 1-cycle glitch, then 9 stable cycles.
  - Response: one accept, 8 cycles after the glitch ends; slot 0 = 00001.
- Test 3, error flags:
  - Stimulus: pattern 1010101 on digit 2; also one episode with `an`=4'b1100.
  - Response: slot 2 = 11111; `out_err`=2'b11 on the frame.
- Test 4, backpressure:
  - Stimulus: complete a frame; hold `out_ready`=0 for 50 cycles while the scan continues with new values.
  - Response: `out_data` unchanged; after the handshake, the next frame contains only post-handshake values.
- Test 5, reset mid-operation:
  - Stimulus: assert `rst_n`=0 asynchronously mid-frame and in HOLD.
  - Response: `out_valid`=0 immediately; `out_data`=0; no frame until 4 fresh accepts.
- Test 6, synchronizer build:
  - Stimulus: with `SEVSEG_CAPTURE_SYNC_EN` defined, rerun Test 1.
  - Response: same data; each accept is 2 cycles later.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Read-back receiver for a multiplexed active-low seven-segment bus: decodes each stable digit
// into the driver's 5-bit code and presents a full frame on valid/ready.
// Optional SEVSEG_CAPTURE_SYNC_EN adds a two-flop synchronizer on seg/an.
module seven_segment_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [5*DIGITS-1:0]   out_data,
  output logic [1:0]            out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StScan, StHold} state_e;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111111: decode = 5'b10000;
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h1F;
    endcase
  endfunction

  logic [6:0]        seg_in;
  logic [DIGITS-1:0] an_in;

`ifdef SEVSEG_CAPTURE_SYNC_EN
  logic [6:0]        seg_s1_q, seg_s2_q;
  logic [DIGITS-1:0] an_s1_q, an_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  assign seg_in = seg_s2_q;
  assign an_in  = an_s2_q;
`else
  assign seg_in = seg;
  assign an_in  = an;
`endif

  logic [6:0]        seg_q, seg_p_q;
  logic [DIGITS-1:0] an_q, an_p_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  state_e            state_q;
  logic [DIGITS-1:0] mask_q;
  logic [DIGITS-1:0][4:0] slot_q;
  logic [1:0]        err_q;
  logic              valid_q;

  logic       changed, open, fire, accept, one_hot, multi_hot;
  logic [3:0] zeros;
  logic [4:0] code;

  always_comb begin
    changed = (seg_q != seg_p_q) || (an_q != an_p_q);
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    zeros = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      zeros = zeros + {3'b000, ~an_q[i]};
    end
    one_hot   = (zeros == 4'd1);
    multi_hot = (zeros > 4'd1);
    code      = decode(seg_q);
    // Frozen once the mask fills, so the frame cannot change before HOLD is entered.
    open      = (state_q == StScan) && !(&mask_q);
    // One decision per stable episode; a change re-arms it.
    fire      = (cnt_d == CntMax) && (changed || !done_q) && open;
    accept    = fire && one_hot;
    if (fire) begin
      done_d = 1'b1;
    end else if (changed) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= 7'h7F;
      an_q    <= '1;
      seg_p_q <= 7'h7F;
      an_p_q  <= '1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      seg_q   <= seg_in;
      an_q    <= an_in;
      seg_p_q <= seg_q;
      an_p_q  <= an_q;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StScan;
      valid_q <= 1'b0;
      mask_q  <= '0;
      slot_q  <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        StScan: begin
          if (&mask_q) begin
            state_q <= StHold;
            valid_q <= 1'b1;
          end
          if (accept) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
              if (!an_q[i]) begin
                slot_q[i] <= code;
                mask_q[i] <= 1'b1;
              end
            end
            if (code == 5'h1F) err_q[0] <= 1'b1;
          end
          if (fire && multi_hot) err_q[1] <= 1'b1;
        end
        StHold: begin
          if (out_ready) begin
            state_q <= StScan;
            valid_q <= 1'b0;
            mask_q  <= '0;
            err_q   <= '0;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  assign out_data  = slot_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (DIGITS=4, STABLE_CYCLES=8); accept timing is seen
// as the target slot of out_data taking its expected code.
module tb_seven_segment_capture;

  localparam int unsigned DIGITS = 4;
`ifdef SEVSEG_CAPTURE_SYNC_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 9;
`endif
  localparam int HOLD_N = LAT + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [19:0] out_data;
  logic [1:0]  out_err;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  seven_segment_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Hold one bus value for n cycles; report the first cycle slot d shows exp and out_valid is 1.
  task automatic drive(input logic [3:0] anv, input logic [6:0] pat, input int n, input int d,
                       input logic [4:0] exp, output int first, output int vfirst);
    seg = pat;
    an  = anv;
    first  = -1;
    vfirst = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (first < 0 && out_data[5*d +: 5] === exp) first = k;
      if (vfirst < 0 && out_valid === 1'b1) vfirst = k;
    end
  endtask

  task automatic idle(input int n);
    seg = 7'h7F;
    an  = 4'hF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [3:0] sel(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic test_reset();
    n_tests++;
    if (out_data !== 20'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 00000", out_data);
    end
    n_tests++;
    if (out_err !== 2'b00) begin
      n_fail++; $display("FAIL reset_err: got %b want 00", out_err);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_code3();
    int f, vf;
    for (int d = 0; d < 4; d++) begin
      drive(sel(d), 7'b0110000, HOLD_N, d, 5'b00011, f, vf);
      n_tests++;
      if (f !== LAT) begin
        n_fail++; $display("FAIL code3_latency d%0d: got %0d want %0d", d, f, LAT);
      end
      if (d == 3) begin
        n_tests++;
        if (vf !== f + 1) begin
          n_fail++; $display("FAIL code3_valid_rise: got cycle %0d want %0d", vf, f + 1);
        end
      end
    end
    n_tests++;
    if (out_data !== 20'h18C63) begin
      n_fail++; $display("FAIL code3_data: got %h want 18c63", out_data);
    end
    n_tests++;
    if (out_err !== 2'b00) begin
      n_fail++; $display("FAIL code3_err: got %b want 00", out_err);
    end
    idle(2);
    handshake();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL code3_handshake: valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_glitch();
    int f, vf;
    drive(sel(0), 7'b1111001, 5, 0, 5'b00001, f, vf);
    n_tests++;
    if (f !== -1) begin
      n_fail++; $display("FAIL glitch_early: accept at %0d want none", f);
    end
    drive(sel(0), 7'b0000000, 1, 0, 5'b00001, f, vf);
    n_tests++;
    if (out_data[4:0] !== 5'b00011) begin
      n_fail++; $display("FAIL glitch_slot_kept: got %b want 00011", out_data[4:0]);
    end
    drive(sel(0), 7'b1111001, LAT, 0, 5'b00001, f, vf);
    n_tests++;
    if (f !== LAT) begin
      n_fail++; $display("FAIL glitch_accept: got cycle %0d want %0d", f, LAT);
    end
  endtask

  task automatic test_errors();
    int f, vf;
    drive(sel(1), 7'b0100100, HOLD_N, 1, 5'b00010, f, vf);
    n_tests++;
    if (out_err !== 2'b00) begin
      n_fail++; $display("FAIL err_clean: got %b want 00", out_err);
    end
    drive(sel(2), 7'b1010101, HOLD_N, 2, 5'b11111, f, vf);
    n_tests++;
    if (f !== LAT) begin
      n_fail++; $display("FAIL err_bad_slot: got cycle %0d want %0d", f, LAT);
    end
    n_tests++;
    if (out_err !== 2'b01) begin
      n_fail++; $display("FAIL err_bad_flag: got %b want 01", out_err);
    end
    drive(4'b1100, 7'b0000000, HOLD_N, 0, 5'b01000, f, vf);
    n_tests++;
    if (out_err !== 2'b11) begin
      n_fail++; $display("FAIL err_multihot_flag: got %b want 11", out_err);
    end
    n_tests++;
    if (out_data !== 20'h1FC41) begin
      n_fail++; $display("FAIL err_multihot_noaccept: got %h want 1fc41", out_data);
    end
    drive(sel(3), 7'b0010010, HOLD_N, 3, 5'b00101, f, vf);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 20'h2FC41 || out_err !== 2'b11) begin
      n_fail++;
      $display("FAIL err_frame: got v=%b d=%h e=%b want v=1 d=2fc41 e=11", out_valid, out_data,
               out_err);
    end
    idle(2);
    handshake();
    n_tests++;
    if (out_valid !== 1'b0 || out_err !== 2'b00) begin
      n_fail++; $display("FAIL err_clear: got v=%b e=%b want v=0 e=00", out_valid, out_err);
    end
  endtask

  task automatic test_backpressure();
    int f, vf;
    logic [6:0] pre [4]  = '{7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000};
    logic [6:0] mid [4]  = '{7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110};
    logic [6:0] post [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [4:0] pre_c [4] = '{5'h07, 5'h08, 5'h09, 5'h0A};
    logic [4:0] post_c [4] = '{5'h01, 5'h02, 5'h03, 5'h04};
    for (int d = 0; d < 4; d++) drive(sel(d), pre[d], HOLD_N, d, pre_c[d], f, vf);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 20'h52507) begin
      n_fail++; $display("FAIL bp_frame: got v=%b d=%h want v=1 d=52507", out_valid, out_data);
    end
    for (int d = 0; d < 4; d++) begin
      drive(sel(d), mid[d], HOLD_N, d, 5'h1E, f, vf);
      n_tests++;
      if (out_data !== 20'h52507) begin
        n_fail++; $display("FAIL bp_frozen d%0d: got %h want 52507", d, out_data);
      end
    end
    idle(2);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_valid_held: got %b want 1", out_valid);
    end
    handshake();
    for (int d = 0; d < 4; d++) drive(sel(d), post[d], HOLD_N, d, post_c[d], f, vf);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 20'h20C41 || out_err !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_next_frame: got v=%b d=%h e=%b want v=1 d=20c41 e=00", out_valid,
               out_data, out_err);
    end
    idle(2);
    handshake();
  endtask

  task automatic test_reset_mid();
    int f, vf;
    drive(sel(0), 7'b0010010, HOLD_N, 0, 5'b00101, f, vf);
    drive(sel(1), 7'b0000010, 4, 1, 5'b00110, f, vf);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_data !== 20'h0 || out_valid !== 1'b0 || out_err !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b d=%h e=%b want v=0 d=00000 e=00", out_valid, out_data,
               out_err);
    end
    @(negedge clk) rst_n = 1'b1;
    drive(sel(1), 7'b0000010, HOLD_N, 1, 5'b00110, f, vf);
    n_tests++;
    if (f !== LAT) begin
      n_fail++; $display("FAIL rst_first_accept: got cycle %0d want %0d", f, LAT);
    end
    drive(sel(2), 7'b1111000, HOLD_N, 2, 5'b00111, f, vf);
    drive(sel(3), 7'b0000000, HOLD_N, 3, 5'b01000, f, vf);
    idle(2);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_early_frame: valid got %b want 0", out_valid);
    end
    drive(sel(0), 7'b0010000, HOLD_N, 0, 5'b01001, f, vf);
    n_tests++;
    if (vf !== f + 1 || out_data !== 20'h41CC9) begin
      n_fail++;
      $display("FAIL rst_fresh_frame: got vcyc=%0d d=%h want vcyc=%0d d=41cc9", vf, out_data,
               f + 1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_data !== 20'h0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_hold: got v=%b d=%h want v=0 d=00000", out_valid, out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    rst_n     = 1'b0;
    seg       = 7'h7F;
    an        = 4'hF;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_code3();
    test_glitch();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
